// File: rtl/seq_add_sub.sv
`timescale 1ns/1ps
// seq_add_sub: multi-cycle adder/subtractor.
// Each RUN cycle sums one CHUNK-bit slice of the operands, LSB slice first.
// A carry register links the slices. Subtraction is done as A + ~B + 1.
// Results and flags are loaded only when the last slice completes, so the
// outputs never show a partial sum. A start/ready and valid/ack handshake
// sequences each operation.
module seq_add_sub #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 ready,
    output logic                 valid,
    input  logic                 ack,
    output logic [OUT_WIDTH-1:0] Q,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets the slicing scheme cannot handle.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("seq_add_sub: WIDTH must be a positive multiple of CHUNK");
        end
        if (OUT_WIDTH < (WIDTH + 1)) begin : g_bad_out
            $error("seq_add_sub: OUT_WIDTH must be at least WIDTH+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One slice of the ripple: {carry, sum} = a + b + cin.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     bx_q, bx_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 sub_q, sub_d;
    logic                 carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] res_q, res_d;
    logic                 cout_q, cout_d;
    logic                 borrow_q, borrow_d;
    logic                 ovf_q, ovf_d;

    logic [CHUNK:0]       slice_s;
    int unsigned          base_s;

    // Next-state, datapath and output-load logic for the three-state sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        bx_d     = bx_q;
        sum_d    = sum_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        cout_d   = cout_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        base_s  = 32'(cnt_q) * 32'(CHUNK);
        slice_s = chunk_add(a_q[base_s +: CHUNK], bx_q[base_s +: CHUNK], carry_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    bx_d    = sub ? ~B : B;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = {CNT_W{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[base_s +: CHUNK] = slice_s[CHUNK-1:0];
                carry_d = slice_s[CHUNK];
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_DONE;
                    // Final load: sum_d now holds the complete WIDTH-bit sum.
                    if (sub_q) begin
                        res_d    = OUT_WIDTH'($signed(sum_d));
                        cout_d   = 1'b0;
                        borrow_d = ~slice_s[CHUNK];
                    end else begin
                        res_d    = OUT_WIDTH'({slice_s[CHUNK], sum_d});
                        cout_d   = slice_s[CHUNK];
                        borrow_d = 1'b0;
                    end
                    ovf_d = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                            (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset discards any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            bx_q     <= {WIDTH{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            res_q    <= {OUT_WIDTH{1'b0}};
            cout_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            sum_q    <= sum_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            cout_q   <= cout_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign Q         = res_q;
    assign carry_out = cout_q;
    assign borrow    = borrow_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_add_sub.sv
`timescale 1ns/1ps
// Testbench for seq_add_sub. A driver issues operations and pushes the
// hand-computed expected response into a queue. A monitor pops and compares
// whenever the default-parameter DUT raises valid. Two extra instances
// cover other CHUNK/WIDTH choices.
module tb_seq_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, sub = 1'b0, ack = 1'b0;
    logic [15:0] A = 16'h0, B = 16'h0;
    logic        ready, valid, carry_out, borrow, overflow;
    logic [31:0] Q;

    // CHUNK=1 instance
    logic        s1_start = 1'b0, s1_sub = 1'b0, s1_ack = 1'b0;
    logic [15:0] s1_A = 16'h0, s1_B = 16'h0;
    logic        s1_ready, s1_valid, s1_cout, s1_borrow, s1_ovf;
    logic [31:0] s1_Q;

    // WIDTH=8, CHUNK=8 instance
    logic        s2_start = 1'b0, s2_sub = 1'b0, s2_ack = 1'b0;
    logic [7:0]  s2_A = 8'h0, s2_B = 8'h0;
    logic        s2_ready, s2_valid, s2_cout, s2_borrow, s2_ovf;
    logic [15:0] s2_Q;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] q;
        logic        c;
        logic        b;
        logic        o;
        int          stamp;
    } exp_t;
    exp_t sb[$];

    seq_add_sub #(.WIDTH(16), .CHUNK(4), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .ready(ready), .valid(valid), .ack(ack), .Q(Q),
        .carry_out(carry_out), .borrow(borrow), .overflow(overflow)
    );

    seq_add_sub #(.WIDTH(16), .CHUNK(1), .OUT_WIDTH(32)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .A(s1_A), .B(s1_B),
        .ready(s1_ready), .valid(s1_valid), .ack(s1_ack), .Q(s1_Q),
        .carry_out(s1_cout), .borrow(s1_borrow), .overflow(s1_ovf)
    );

    seq_add_sub #(.WIDTH(8), .CHUNK(8), .OUT_WIDTH(16)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .sub(s2_sub), .A(s2_A), .B(s2_B),
        .ready(s2_ready), .valid(s2_valid), .ack(s2_ack), .Q(s2_Q),
        .carry_out(s2_cout), .borrow(s2_borrow), .overflow(s2_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: first valid cycle pops and checks; later valid cycles check hold.
    logic in_valid = 1'b0;
    logic have_cur = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_valid = 1'b0;
            have_cur = 1'b0;
        end else if (valid) begin
            if (!in_valid) begin
                in_valid = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    chk("latency", 64'(cyc - cur.stamp), 64'd4);
                    chk("Q", 64'(Q), 64'(cur.q));
                    chk("carry_out", 64'(carry_out), 64'(cur.c));
                    chk("borrow", 64'(borrow), 64'(cur.b));
                    chk("overflow", 64'(overflow), 64'(cur.o));
                end
            end else if (have_cur) begin
                chk("Q_held", 64'(Q), 64'(cur.q));
            end
        end else begin
            if (in_valid && have_cur) begin
                chk("Q_retained", 64'(Q), 64'(cur.q));
            end
            in_valid = 1'b0;
            have_cur = 1'b0;
        end
    end

    // Issue one operation; returns at the negedge after the start edge.
    task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic ec, input logic eb, input logic eo);
        int n;
        exp_t e;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        start = 1'b1;
        sub = s;
        A = a;
        B = b;
        e.q = eq; e.c = ec; e.b = eb; e.o = eo; e.stamp = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        sub = ~s;
        A = 16'hDEAD;
        B = 16'hBEEF;
    endtask

    // Wait for valid, keep ack low for 'hold' cycles, then acknowledge.
    task automatic finish_op(input int hold);
        int n;
        n = 0;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk("valid_timeout", 64'd0, 64'd1);
        repeat (hold) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ready_after_ack", 64'(ready), 64'd1);
        chk("valid_after_ack", 64'(valid), 64'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_Q", 64'(Q), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd1);

        // Basic add and subtract vectors
        issue(1'b0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
        finish_op(0);
        issue(1'b1, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        finish_op(1);
        issue(1'b1, 16'h0005, 16'h0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        finish_op(0);
        issue(1'b0, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b0, 1'b0, 1'b1);
        finish_op(0);
        issue(1'b1, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b0, 1'b0, 1'b1);
        finish_op(0);

        // start pulses in RUN cycles 2 and 3 must be ignored
        issue(1'b0, 16'h1111, 16'h2222, 32'h0000_3333, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; sub = 1'b1; A = 16'h0F0F; B = 16'h0101;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; A = 16'hAAAA; B = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        // hold ack low for 10 cycles; monitor checks Q every valid cycle
        finish_op(10);

        // ack together with start: only one completion
        issue(1'b0, 16'h00F0, 16'h000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk("valid_timeout", 64'd0, 64'd1);
        ack = 1'b1; start = 1'b1; sub = 1'b0; A = 16'h0001; B = 16'h0001;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        chk("ackstart_ready", 64'(ready), 64'd1);
        chk("ackstart_valid", 64'(valid), 64'd0);
        repeat (8) @(negedge clk);
        chk("ackstart_no_second", 64'(valid), 64'd0);

        // Asynchronous reset during chunk 2
        issue(1'b0, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_Q", 64'(Q), 64'd0);
        chk("arst_flags", 64'({carry_out, borrow, overflow}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        finish_op(0);

        // CHUNK=1: latency 16 edges
        s1_start = 1'b1; s1_sub = 1'b0; s1_A = 16'h1234; s1_B = 16'h0101;
        @(negedge clk);
        s1_start = 1'b0; s1_A = 16'h0; s1_B = 16'h0;
        n = 0;
        while (!s1_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("c1_latency", 64'(n), 64'd16);
        chk("c1_Q", 64'(s1_Q), 64'h0000_1335);
        s1_ack = 1'b1;
        @(negedge clk);
        s1_ack = 1'b0;
        chk("c1_ready", 64'(s1_ready), 64'd1);

        // WIDTH=8, CHUNK=8: latency 1 edge
        s2_start = 1'b1; s2_sub = 1'b0; s2_A = 8'hFF; s2_B = 8'hFF;
        @(negedge clk);
        s2_start = 1'b0; s2_A = 8'h0; s2_B = 8'h0;
        n = 0;
        while (!s2_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", 64'(n), 64'd1);
        chk("w8_Q", 64'(s2_Q), 64'h01FE);
        chk("w8_carry", 64'(s2_cout), 64'd1);
        s2_ack = 1'b1;
        @(negedge clk);
        s2_ack = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
Multi-cycle, parametrised adder/subtractor for the calculator datapath. It processes CHUNK bits per clock using a carry register between chunks, and supports add and subtract modes. Results are presented on a registered, zero- or sign-extended output with carry, borrow and signed-overflow flags. It uses a start/ready and valid/ack handshake so the calculator control FSM can sequence operations.

Parameters:
WIDTH, 16, operand width in bits
CHUNK, 4, bits summed per clock; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise)
OUT_WIDTH, 32, result width; must be >= WIDTH+1 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request an operation; sampled only when ready=1
sub  input  1  operation select, sampled with start: 0=A+B, 1=A-B
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
ready  output  1  high in IDLE; start is accepted only when high
valid  output  1  result and flags valid; held until ack
ack  input  1  consumer accepts the result; meaningful only when valid=1
Q  output  OUT_WIDTH  result
carry_out  output  1  add: carry out of bit WIDTH-1; sub: 0
borrow  output  1  sub: 1 when A<B (unsigned); add: 0
overflow  output  1  two's-complement overflow of the WIDTH-bit operation

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset while rst_n=0, including mid-operation: state=IDLE, ready=1, valid=0, Q=0, carry_out=0, borrow=0, overflow=0, all internal registers cleared. Any in-flight operation is discarded.
- N = WIDTH/CHUNK. There are three states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch A and sub.
  - latch Bx = sub ? ~B : B.
  - carry register = sub; chunk counter = 0; go to RUN.
  - ready=0 from edge k onward.
- RUN, on each edge:
  - {c, s} = A_chunk[i] + Bx_chunk[i] + carry, where chunk i covers bits i*CHUNK .. i*CHUNK+CHUNK-1, LSB chunk first.
  - s is stored into the partial-sum register; carry = c; counter increments.
  - After the chunk N-1 edge (edge k+N): go to DONE, load outputs, set valid=1.
- Latency: valid first observed high after edge k+N (4 edges for the defaults). Q and flags never show partial results.
- Output load at RUN->DONE, with S the WIDTH-bit sum and cf the final carry:
  - add: Q = zero-extend({cf, S}); carry_out = cf; borrow = 0.
  - sub: Q = sign-extend(S) to OUT_WIDTH; carry_out = 0; borrow = ~cf.
  - overflow = (A[W-1] == Bx[W-1]) && (S[W-1] != A[W-1]).
- DONE: valid=1 and outputs held stable until an edge with ack=1, then valid=0 and the block goes to IDLE (ready=1 next cycle).
- Q and flags retain their last values after ack until the next completion.
- start while not IDLE is ignored, with no queuing. start and ack in the same DONE cycle: ack is honoured and start is ignored; start must be reasserted once ready=1.
- ack while valid=0 is ignored.
- A, B and sub changing during RUN or DONE have no effect.

Test Plan:
1. Defaults. After reset, check ready=1, valid=0, Q=0. Then start, add, A=0xFFFF, B=0x0001 -> valid after exactly 4 edges; Q=0x00010000, carry_out=1, overflow=0.
2. Subtract, A=0x0003, B=0x0005 -> Q=0xFFFFFFFE, borrow=1, overflow=0. Subtract, A=0x0005, B=0x0003 -> Q=0x00000002, borrow=0.
3. Add, A=0x7FFF, B=0x0001 -> Q=0x00008000, overflow=1. Subtract, A=0x8000, B=0x0001 -> Q=0x00007FFF, overflow=1.
4. Handshake:
   - pulse start in cycles 2 and 3 of RUN with different operands -> ignored, first result unchanged;
   - hold ack=0 for 10 cycles -> valid and Q stable;
   - ack and start together -> one completion only, ready=1 the next cycle.
5. Assert rst_n=0 during chunk 2 of add 0x1234+0x4321 -> all outputs 0 and IDLE immediately (asynchronous). After release, start 0x1234+0x4321 -> Q=0x00005555.
6. Parameter sweep: CHUNK=1, WIDTH=16 -> latency 16 edges. WIDTH=8, CHUNK=8, OUT_WIDTH=16, add 0xFF+0xFF -> Q=0x01FE after 1 edge.
